// File: rtl/apb_pkg.sv
`default_nettype none
// apb_pkg: state encoding, default widths and command type shared by the APB round-robin arbiter.
package apb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_SETUP  = 2'b01;
  localparam logic [1:0] ST_ACCESS = 2'b10;

  localparam int APB_DEF_AW = 8;
  localparam int APB_DEF_DW = 32;

  typedef struct packed {
    logic                  write;
    logic [APB_DEF_AW-1:0] addr;
    logic [APB_DEF_DW-1:0] wdata;
  } apb_cmd_t;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// rr_picker: combinational round-robin selector, first eligible request scanning up from last+1.
module rr_picker
  import apb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_masked,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   gnt_idx,
  output logic            any
);

  // Walk offsets from farthest to nearest so the nearest eligible one overwrites.
  always_comb begin
    gnt_idx = last;
    any     = 1'b0;
    for (int i = NREQ; i >= 1; i--) begin
      if (req_masked[(int'(last) + i) % NREQ]) begin
        gnt_idx = IW'((int'(last) + i) % NREQ);
        any     = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_rr_arbiter.sv
`default_nettype none
// apb_rr_arbiter: shares one APB master port among NREQ requesters with round-robin
// arbitration, wait-state handling and an optional wait-state timeout.
module apb_rr_arbiter
  import apb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int AW       = APB_DEF_AW,
  parameter int DW       = APB_DEF_DW,
  parameter int MAX_WAIT = 15
) (
  input  logic            PCLK,
  input  logic            PRESET,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0] done,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            busy,
  output logic            PSEL,
  output logic            PENABLE,
  output logic            PWRITE,
  output logic [AW-1:0]   PADDR,
  output logic [DW-1:0]   PWDATA,
  input  logic [DW-1:0]   PRDATA,
  input  logic            PREADY,
  input  logic            PSLVERR
);

  localparam int IW  = $clog2(NREQ);
  localparam int WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [1:0]      r_state;
  logic [IW-1:0]   r_last;
  logic [WCW-1:0]  r_wait;
  logic [NREQ-1:0] r_done;
  logic [DW-1:0]   r_rdata;
  logic            r_err;
  logic            r_psel;
  logic            r_penable;
  logic            r_pwrite;
  logic [AW-1:0]   r_paddr;
  logic [DW-1:0]   r_pwdata;

  logic [NREQ-1:0] w_eligible;
  logic [IW-1:0]   w_gnt_idx;
  logic            w_any;
  logic            w_sel_write;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;
  logic [WCW:0]    w_wait_inc;
  logic            w_timeout;
  logic [NREQ-1:0] w_last_onehot;

  // done is one-hot on the requester just completed, so it doubles as the mask.
  assign w_eligible = req & ~r_done;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req_masked (w_eligible),
    .last       (r_last),
    .gnt_idx    (w_gnt_idx),
    .any        (w_any)
  );

  assign w_sel_write   = req_write[w_gnt_idx];
  assign w_sel_addr    = req_addr[w_gnt_idx*AW +: AW];
  assign w_sel_wdata   = req_wdata[w_gnt_idx*DW +: DW];
  assign w_wait_inc    = {1'b0, r_wait} + (WCW+1)'(1);
  assign w_timeout     = (MAX_WAIT != 0) && (w_wait_inc == (WCW+1)'(MAX_WAIT));
  assign w_last_onehot = NREQ'(1) << r_last;

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_state   <= ST_IDLE;
      r_last    <= IW'(NREQ - 1);
      r_wait    <= '0;
      r_done    <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else begin
      r_done  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_last   <= w_gnt_idx;
            r_psel   <= 1'b1;
            r_pwrite <= w_sel_write;
            r_paddr  <= w_sel_addr;
            r_pwdata <= w_sel_write ? w_sel_wdata : '0;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_wait    <= '0;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY || w_timeout) begin
            r_done    <= w_last_onehot;
            r_rdata   <= (PREADY && !r_pwrite) ? PRDATA : '0;
            r_err     <= PREADY ? PSLVERR : 1'b1;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_wait <= w_wait_inc[WCW-1:0];
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign done      = r_done;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign busy      = (r_state != ST_IDLE);
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_rr_arbiter.sv
`default_nettype none
// tb_apb_rr_arbiter: scenario tasks plus a completion scoreboard for apb_rr_arbiter.
module tb_apb_rr_arbiter;
  import apb_pkg::*;

  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 32;

  logic            PCLK = 1'b0;
  logic            PRESET;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0] done;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            busy;
  logic            PSEL, PENABLE, PWRITE;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA;
  logic [DW-1:0]   PRDATA;
  logic            PREADY;
  logic            PSLVERR;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_errors = 0;

  apb_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_WAIT(15)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .done(done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Completion monitor: every done pulse must match the next expected completion.
  always @(negedge PCLK) begin
    if (done !== '0) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected_done: got done=%b, required no completion", done);
      end else begin
        m_e = sb.pop_front();
        if (done !== (4'b0001 << m_e.idx) || rsp_rdata !== m_e.rdata || rsp_err !== m_e.err) begin
          n_errors++;
          $display("FAIL sb_completion: got done=%b rdata=%h err=%b, required done=%b rdata=%h err=%b",
                   done, rsp_rdata, rsp_err, 4'b0001 << m_e.idx, m_e.rdata, m_e.err);
        end
      end
    end else if (rsp_rdata !== '0 || rsp_err !== 1'b0) begin
      n_checks++;
      n_errors++;
      $display("FAIL rsp_idle_clear: got rdata=%h err=%b with no done, required 0/0", rsp_rdata, rsp_err);
    end
  end

  task automatic set_cmd(input int i, input apb_cmd_t c);
    req_write[i]          = c.write;
    req_addr[i*AW +: AW]  = c.addr;
    req_wdata[i*DW +: DW] = c.wdata;
  endtask

  task automatic test_reset();
    PRESET = 1'b0; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
    repeat (2) @(negedge PCLK);
    n_checks++;
    if ({PSEL, PENABLE, PWRITE, busy, rsp_err} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got psel/pen/pwr/busy/err=%b, required 00000",
               {PSEL, PENABLE, PWRITE, busy, rsp_err});
    end
    n_checks++;
    if (PADDR !== '0 || PWDATA !== '0 || done !== '0 || rsp_rdata !== '0) begin
      n_errors++;
      $display("FAIL reset_data: got paddr=%h pwdata=%h done=%b rdata=%h, required all 0",
               PADDR, PWDATA, done, rsp_rdata);
    end
    PRESET = 1'b1;
    @(negedge PCLK);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_round_robin();
    int ng = 0;
    int gidx[5];
    int gcyc[5];
    logic [NREQ-1:0] rearm = '0;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NREQ; i++) set_cmd(i, '{1'b1, 8'(8'h40 + i), 32'h1000 + i});
    for (int i = 0; i < 5; i++) sb.push_back('{exp_order[i], 32'h0, 1'b0});
    req = '1;
    for (int k = 0; k < 60; k++) begin
      @(negedge PCLK);
      req   = req | rearm;
      rearm = '0;
      if (done !== '0) begin
        req = req & ~done;
        if (ng < 5) rearm = done;
      end
      if (PSEL && !PENABLE && ng < 5) begin
        gidx[ng] = int'(PADDR) - 'h40;
        gcyc[ng] = k;
        ng++;
        if (ng == 5) req = req & 4'b0001;
      end
      if (ng == 5 && req == '0 && sb.size() == 0) break;
    end
    n_checks++;
    if (ng != 5) begin
      n_errors++;
      $display("FAIL rr_grant_count: got %0d grants, required 5", ng);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (gidx[i] != exp_order[i]) begin
          n_errors++;
          $display("FAIL rr_order[%0d]: got requester %0d, required %0d", i, gidx[i], exp_order[i]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (gcyc[i+1] - gcyc[i] != 3) begin
          n_errors++;
          $display("FAIL rr_period[%0d]: got %0d cycles, required 3", i, gcyc[i+1] - gcyc[i]);
        end
      end
    end
    req = '0;
    @(negedge PCLK);
  endtask

  task automatic test_single_write();
    set_cmd(2, '{1'b1, 8'h3C, 32'hDEADBEEF});
    PREADY = 1'b1;
    sb.push_back('{2, 32'h0, 1'b0});
    req = 4'b0100;
    @(negedge PCLK);
    n_checks++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PWRITE !== 1'b1 || PADDR !== 8'h3C || PWDATA !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL wr_setup: got psel=%b pen=%b pwr=%b addr=%h data=%h, required 1 0 1 3c deadbeef",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    end
    @(negedge PCLK);
    n_checks++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
      n_errors++;
      $display("FAIL wr_access: got psel=%b pen=%b, required 1 1", PSEL, PENABLE);
    end
    @(negedge PCLK);
    n_checks++;
    if (done !== 4'b0100 || rsp_err !== 1'b0 || PSEL !== 1'b0) begin
      n_errors++;
      $display("FAIL wr_done: got done=%b err=%b psel=%b, required 0100 0 0", done, rsp_err, PSEL);
    end
    req = '0;
    @(negedge PCLK);
  endtask

  task automatic test_read_wait();
    int  acc = 0;
    logic got = 1'b0;
    set_cmd(0, '{1'b0, 8'h10, 32'hCAFE0000});
    PREADY = 1'b0; PRDATA = 32'h12345678;
    sb.push_back('{0, 32'h12345678, 1'b0});
    req = 4'b0001;
    @(negedge PCLK);
    n_checks++;
    if (PSEL !== 1'b1 || PWRITE !== 1'b0 || PADDR !== 8'h10 || PWDATA !== '0) begin
      n_errors++;
      $display("FAIL rd_setup: got psel=%b pwr=%b addr=%h data=%h, required 1 0 10 0",
               PSEL, PWRITE, PADDR, PWDATA);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge PCLK);
      if (done !== '0) begin got = 1'b1; break; end
      if (PENABLE) acc++;
      if (acc == 4) PREADY = 1'b1;
    end
    n_checks++;
    if (!got || acc != 4) begin
      n_errors++;
      $display("FAIL rd_access_len: got %0d access cycles (done seen=%b), required 4", acc, got);
    end
    n_checks++;
    if (done !== 4'b0001 || rsp_rdata !== 32'h12345678) begin
      n_errors++;
      $display("FAIL rd_done: got done=%b rdata=%h, required 0001 12345678", done, rsp_rdata);
    end
    req = '0; PREADY = 1'b1;
    @(negedge PCLK);
    n_checks++;
    if (rsp_rdata !== '0 || done !== '0) begin
      n_errors++;
      $display("FAIL rd_clear: got done=%b rdata=%h, required 0000 0", done, rsp_rdata);
    end
  endtask

  task automatic test_rerequest();
    logic got = 1'b0;
    set_cmd(1, '{1'b0, 8'h20, 32'h0});
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'hA5A50001;
    sb.push_back('{1, 32'hA5A50001, 1'b0});
    sb.push_back('{1, 32'hA5A50002, 1'b1});
    req = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      @(negedge PCLK);
      if (done !== '0) begin got = 1'b1; break; end
    end
    n_checks++;
    if (!got || done !== 4'b0010) begin
      n_errors++;
      $display("FAIL rereq_first_done: got done=%b, required 0010", done);
    end
    PRDATA = 32'hA5A50002; PSLVERR = 1'b1;
    @(negedge PCLK);
    n_checks++;
    if (PSEL !== 1'b0) begin
      n_errors++;
      $display("FAIL rereq_masked: got psel=%b one cycle after done, required 0", PSEL);
    end
    @(negedge PCLK);
    n_checks++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 8'h20) begin
      n_errors++;
      $display("FAIL rereq_grant: got psel=%b pen=%b addr=%h, required 1 0 20", PSEL, PENABLE, PADDR);
    end
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge PCLK);
      if (done !== '0) begin got = 1'b1; break; end
    end
    n_checks++;
    if (!got || rsp_err !== 1'b1 || rsp_rdata !== 32'hA5A50002) begin
      n_errors++;
      $display("FAIL rereq_slverr: got done_seen=%b err=%b rdata=%h, required 1 1 a5a50002",
               got, rsp_err, rsp_rdata);
    end
    req = '0; PSLVERR = 1'b0;
    @(negedge PCLK);
  endtask

  task automatic test_timeout();
    int  acc = 0;
    logic got = 1'b0;
    set_cmd(3, '{1'b0, 8'h30, 32'h0});
    PREADY = 1'b0; PRDATA = 32'hFFFFFFFF;
    sb.push_back('{3, 32'h0, 1'b1});
    req = 4'b1000;
    for (int k = 0; k < 40; k++) begin
      @(negedge PCLK);
      if (done !== '0) begin got = 1'b1; break; end
      if (PENABLE) acc++;
    end
    n_checks++;
    if (!got || acc != 15) begin
      n_errors++;
      $display("FAIL to_length: got %0d access cycles (done seen=%b), required 15", acc, got);
    end
    n_checks++;
    if (done !== 4'b1000 || rsp_err !== 1'b1 || rsp_rdata !== '0 || PSEL !== 1'b0) begin
      n_errors++;
      $display("FAIL to_done: got done=%b err=%b rdata=%h psel=%b, required 1000 1 0 0",
               done, rsp_err, rsp_rdata, PSEL);
    end
    req = '0; PREADY = 1'b1; PRDATA = '0;
    @(negedge PCLK);
  endtask

  task automatic test_reset_mid_access();
    logic got = 1'b0;
    set_cmd(2, '{1'b0, 8'h60, 32'h0});
    PREADY = 1'b0;
    req = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      @(negedge PCLK);
      if (PENABLE === 1'b1) begin got = 1'b1; break; end
    end
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL rst_reach_access: got no ACCESS phase within bound, required one");
    end
    #2 PRESET = 1'b0;
    #1;
    n_checks++;
    if ({PSEL, PENABLE, busy, done, rsp_err} !== 8'b0 || PADDR !== '0) begin
      n_errors++;
      $display("FAIL rst_async: got psel=%b pen=%b busy=%b done=%b addr=%h, required all 0",
               PSEL, PENABLE, busy, done, PADDR);
    end
    req = '0;
    @(negedge PCLK);
    PRESET = 1'b1;
    set_cmd(0, '{1'b0, 8'h50, 32'h0});
    set_cmd(3, '{1'b0, 8'h70, 32'h0});
    PREADY = 1'b1; PRDATA = 32'h0BADF00D;
    sb.push_back('{0, 32'h0BADF00D, 1'b0});
    req = 4'b1001;
    @(negedge PCLK);
    n_checks++;
    if (PSEL !== 1'b1 || PADDR !== 8'h50) begin
      n_errors++;
      $display("FAIL rst_first_grant: got psel=%b addr=%h, required 1 50", PSEL, PADDR);
    end
    req = 4'b0001;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge PCLK);
      if (done !== '0) begin got = 1'b1; break; end
    end
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL rst_post_done: got no done within bound, required one");
    end
    req = '0;
    @(negedge PCLK);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_write();
    test_read_wait();
    test_rerequest();
    test_timeout();
    test_reset_mid_access();
    repeat (3) @(negedge PCLK);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: got %0d outstanding completions, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_rr_arbiter.md
# apb_rr_arbiter

Shares one APB master port among `NREQ` local requesters using round-robin arbitration, and sequences each granted command through the APB SETUP and ACCESS phases. It handles slave wait states and aborts on a wait-state timeout. It returns read data and error status to the requester that owned the transfer. It sits between the peripheral-facing bus and the block-level command sources.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `AW`, 8: address width.
- `DW`, 32: data width.
- `MAX_WAIT`, 15: maximum number of ACCESS cycles with `PREADY`=0 before abort. 0 disables the timeout.
- `PCLK`  in  1  bus clock.
- `PRESET`  in  1  reset, asynchronous, active-low.
- `req`  in  NREQ  per-requester request; held high until that requester's `done` bit.
- `req_write`  in  NREQ  per-requester direction: 1 = write.
- `req_addr`  in  NREQ*AW  flattened addresses; requester i uses bits [i*AW +: AW].
- `req_wdata`  in  NREQ*DW  flattened write data, same packing.
- `done`  out  NREQ  one-cycle completion pulse, one-hot.
- `rsp_rdata`  out  DW  read data; valid while `done` is high.
- `rsp_err`  out  1  `PSLVERR` or timeout; valid while `done` is high.
- `busy`  out  1  a transfer is in progress (state ≠ IDLE).
- `PSEL`, `PENABLE`, `PWRITE`  out  1  APB control, registered.
- `PADDR`  out  AW  registered.
- `PWDATA`  out  DW  registered.
- `PRDATA`  in  DW  APB read data.
- `PREADY`  in  1  APB ready.
- `PSLVERR`  in  1  APB slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE:**
  - Eligible requests are `req & ~mask`.
  - `mask` is the one-hot index of the requester that was just completed while its `done` is high; otherwise `mask` is 0.
  - If any request is eligible, pick the first set bit scanning from `last+1` upward, wrapping at NREQ.
  - Latch that requester's write, addr and wdata into `PWRITE`/`PADDR`/`PWDATA`. For a read, `PWDATA` = 0.
  - Set `last` to the picked index, set `PSEL`=1, and go to SETUP.
- **SETUP:** `PENABLE`←1, clear the wait counter, go to ACCESS. No input is sampled in this state.
- **ACCESS with `PREADY`=1:**
  - `done[last]`←1.
  - `rsp_rdata`←`PRDATA` if read, else 0.
  - `rsp_err`←`PSLVERR`.
  - `PSEL`/`PENABLE`/`PWRITE`/`PADDR`/`PWDATA`←0.
  - Go to IDLE.
- **ACCESS with `PREADY`=0:**
  - Increment the wait counter. Its width is clog2(MAX_WAIT+1).
  - If the counter reaches MAX_WAIT (and MAX_WAIT≠0), abort: `done[last]`←1, `rsp_err`←1, `rsp_rdata`←0, APB outputs cleared, go to IDLE.
- Requester inputs are ignored from SETUP until the return to IDLE. The latched command is immune to input changes.
- A requester must drop `req` at the clock edge that ends its `done` cycle. If `req` is still high one cycle later, it is a new request.
- `done`, `rsp_rdata` and `rsp_err` are cleared to 0 in every cycle without a completion.
- Round-robin pointer `last` resets to NREQ-1, so requester 0 wins the first arbitration.

## Timing
- Reset values: `PSEL`, `PENABLE`, `PWRITE`, `PADDR`, `PWDATA`, `done`, `rsp_rdata`, `rsp_err`, `busy` are all 0. State is IDLE and `last` = NREQ-1.
- **Latency, no wait states:**
  - `req` sampled high at edge 0.
  - SETUP cycle 1.
  - ACCESS cycle 2, with `PREADY` sampled at edge 3.
  - `done` high in cycle 3, which is also the next IDLE arbitration cycle.
- Back-to-back period is 3 cycles per transfer. Each `PREADY`=0 cycle adds one.
- A timeout completes MAX_WAIT ACCESS cycles after entering ACCESS.
- **Reset mid-transfer:** immediate return to IDLE, all outputs 0, no `done` issued.
- **Simultaneous requests:** resolved only by round-robin order from `last+1`. Exactly one grant per IDLE cycle.

## Structure
- Shared package `apb_pkg`:
  - State encoding IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10.
  - Default AW/DW constants.
  - `apb_cmd_t` struct {write, addr, wdata}.
- Sub-module `rr_picker`: combinational. Inputs `req_masked` and `last`; outputs `gnt_idx` and `any`.

## Test plan
- **Single write.** Requester 2 requests a write to 0x3C with data 0xDEADBEEF, `PREADY`=1. Required: SETUP in cycle 1 with `PADDR`=0x3C and `PWRITE`=1, then `PENABLE`=1 in cycle 2, then `done`=4'b0100 in cycle 3 with `rsp_err`=0.
- **Single read with wait states.** Requester 0 reads 0x10; `PREADY` is low for 3 cycles; `PRDATA`=0x1234_5678. Required: ACCESS lasts 4 cycles, `done`=4'b0001, `rsp_rdata`=0x12345678.
- **Round-robin fairness.** All 4 requesters hold `req` and re-request immediately after their `done`. Required: grant order 0,1,2,3,0, with a 3-cycle period each and no starvation.
- **Same-cycle re-request.** Requester 1 keeps `req` high through its `done` cycle while no one else requests. Required: it is not regranted in that cycle; it is granted in the following cycle.
- **Timeout.** MAX_WAIT=15 and `PREADY` is held low. Required: `done` arrives after 15 ACCESS cycles with `rsp_err`=1 and `rsp_rdata`=0, and `PSEL` drops.
- **Reset mid-ACCESS.** `PRESET` is pulled low during ACCESS. Required: all outputs become 0 asynchronously, no `done` is issued, and requester 0 wins the first arbitration after reset.
